// File: rtl/skinny_ti_pkg.sv
// Shared types and constants for the 3-share inverse SKINNY-64 S-box.
package skinny_ti_pkg;

    localparam int SHARE_W = 4;
    localparam int SHARE_N = 3;

    typedef logic [SHARE_W-1:0] share_t;
    // Index 0 is share 1, index 2 is share 3.
    typedef share_t [SHARE_N-1:0] shares_t;

    // Unmasked inverse S-box, kept as a reference value only.
    localparam logic [3:0] SINV_TABLE [16] = '{
        4'h3, 4'h4, 4'h6, 4'h8, 4'hc, 4'ha, 4'h1, 4'he,
        4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hb, 4'hd, 4'hf
    };

    function automatic share_t rot_r(input share_t v);
        return {v[0], v[3:1]};
    endfunction

endpackage

// File: rtl/skinny_inv_sbox_ti_if.sv
// Valid/ready stream carrying three input shares in and three output shares out.
interface skinny_inv_sbox_ti_if;
    import skinny_ti_pkg::*;

    logic   in_valid;
    logic   in_ready;
    share_t x1;
    share_t x2;
    share_t x3;
    logic   out_valid;
    logic   out_ready;
    share_t y1;
    share_t y2;
    share_t y3;

    modport master (
        output in_valid, x1, x2, x3, out_ready,
        input  in_ready, out_valid, y1, y2, y3
    );

    modport slave (
        input  in_valid, x1, x2, x3, out_ready,
        output in_ready, out_valid, y1, y2, y3
    );

endinterface

// File: rtl/skinny_inv_ti_stage.sv
// One combinational TI layer: optional rotate-right on every share, then masked Q.
module skinny_inv_ti_stage
    import skinny_ti_pkg::*;
#(
    parameter bit FIRST = 1'b0
) (
    input  shares_t din,
    output shares_t dout
);

    shares_t r;
    logic    a1, a2, a3;
    logic    b1, b2, b3;
    logic    z1, z2, z3;

    always_comb begin
        r = din;
        if (!FIRST) begin
            for (int i = 0; i < SHARE_N; i++) begin
                r[i] = rot_r(din[i]);
            end
        end
    end

    // NOR(v3,v2) = (~v3)&(~v2); the complement sits on share 1 only.
    assign a1 = ~r[0][3];
    assign a2 =  r[1][3];
    assign a3 =  r[2][3];
    assign b1 = ~r[0][2];
    assign b2 =  r[1][2];
    assign b3 =  r[2][2];

    // Each z term omits one share index, so every new bit 0 sees only two shares.
    assign z1 = (a2 & b2) ^ (a2 & b3) ^ (a3 & b2);
    assign z2 = (a3 & b3) ^ (a1 & b3) ^ (a3 & b1);
    assign z3 = (a1 & b1) ^ (a1 & b2) ^ (a2 & b1);

    assign dout[0] = {r[0][3:1], r[1][0] ^ z1};
    assign dout[1] = {r[1][3:1], r[2][0] ^ z2};
    assign dout[2] = {r[2][3:1], r[0][0] ^ z3};

endmodule

// File: rtl/skinny_inv_sbox_ti.sv
// 4-stage registered threshold implementation of the inverse SKINNY-64 S-box
// with a valid/ready stream and full backpressure.
module skinny_inv_sbox_ti
    import skinny_ti_pkg::*;
#(
    parameter int STAGES = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    skinny_inv_sbox_ti_if.slave bus
);

    generate
        if (STAGES != 4) begin : g_stages_check
            $error("skinny_inv_sbox_ti: STAGES must be 4");
        end
    endgenerate

    shares_t             stage_in  [STAGES];
    shares_t             stage_out [STAGES];
    shares_t             stage_q   [STAGES];
    logic [STAGES-1:0]   vld_q;
    logic [STAGES-1:0]   vld_in;
    logic                stall;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign stage_in[k] = {bus.x3, bus.x2, bus.x1};
            end else begin : g_tail
                assign stage_in[k] = stage_q[k-1];
            end

            skinny_inv_ti_stage #(
                .FIRST (k == 0)
            ) u_stage (
                .din  (stage_in[k]),
                .dout (stage_out[k])
            );
        end
    endgenerate

    assign stall        = vld_q[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready = ~stall;
    assign vld_in       = {vld_q[STAGES-2:0], bus.in_valid};

    // Share registers load only with a valid evaluation so bubbles never
    // toggle the masked data path; all three shares always load together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q <= vld_in;
            for (int i = 0; i < STAGES; i++) begin
                if (vld_in[i]) begin
                    stage_q[i] <= stage_out[i];
                end
            end
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.y1        = stage_q[STAGES-1][0];
    assign bus.y2        = stage_q[STAGES-1][1];
    assign bus.y3        = stage_q[STAGES-1][2];

endmodule
